// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-2 Booth signed multiplier
module booth_mul_seq #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N+1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [N:0]    ONE_W   = (N+1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_LST = CW'(N-1);

    state_t           state_q, state_d;
    logic [N:0]       ac_q, ac_d;
    logic [N:0]       mreg_q, mreg_d;
    logic [N-1:0]     q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [N:0]       sum;

    // Booth recoding of {Q[0], q_m1}: add M, subtract M, or pass AC through
    always_comb begin
        sum = ac_q;
        case ({q_q[0], qm1_q})
            2'b01:   sum = ac_q + mreg_q;
            2'b10:   sum = ac_q + ~mreg_q + ONE_W;
            default: sum = ac_q;
        endcase
    end

    // Next-state, datapath update and registered-output preparation
    always_comb begin
        state_d   = state_q;
        ac_d      = ac_q;
        mreg_d    = mreg_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ac_d    = '0;
                    mreg_d  = {multiplicand[N-1], multiplicand};
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // arithmetic shift right of {sum, Q, q_m1}
                ac_d  = {sum[N], sum[N:1]};
                q_d   = {sum[0], q_q[N-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LST) begin
                    product_d = {ac_d[N-1:0], q_d};
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset discards any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ac_q      <= '0;
            mreg_q    <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ac_q      <= ac_d;
            mreg_q    <= mreg_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - scoreboard bench for booth_mul_seq
module tb_booth_mul_seq;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int total;
    int bad;
    int done_cnt;
    logic done_prev;
    logic [2*N-1:0] exp_q[$];

    booth_mul_seq #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] mul_ref(input logic [N-1:0] m, input logic [N-1:0] q);
        logic signed [2*N-1:0] r;
        r = $signed(m) * $signed(q);
        return r;
    endfunction

    // Output monitor: every done pulse retires one scoreboard entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && done_prev)
                check("done_width", 32'(done_prev), 32'd0);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0)
                    check("unexpected_done", 32'd1, 32'd0);
                else
                    check("product", 32'(product), 32'(exp_q.pop_front()));
            end
        end
        done_prev = done;
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (cyc > 40) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic run_one(input logic [N-1:0] m, input logic [N-1:0] q, input logic [2*N-1:0] exp);
        int cyc;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(cyc);
        check("done_latency", 32'(cyc), 32'(N));
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_after_done", 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int dc0;
        logic [N-1:0] rm, rq;
        total        = 0;
        bad          = 0;
        done_cnt     = 0;
        done_prev    = 1'b0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        rst_n = 1'b1;

        run_one(8'd7,   8'd3,   16'h0015);
        run_one(8'hFB,  8'd6,   16'hFFE2);
        run_one(8'd6,   8'hFB,  16'hFFE2);
        run_one(8'h80,  8'h80,  16'h4000);
        run_one(8'h80,  8'h7F,  16'hC080);
        run_one(8'd0,   8'hFF,  16'h0000);
        run_one(8'h7F,  8'h7F,  16'h3F01);
        for (int i = 0; i < 10; i++) begin
            rm = N'($urandom);
            rq = N'($urandom);
            run_one(rm, rq, mul_ref(rm, rq));
        end

        // start while busy is ignored
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd9; multiplier = 8'hFD;
        exp_q.push_back(16'hFFE5);
        @(negedge clk);
        start = 1'b0; multiplicand = 8'd0; multiplier = 8'd0;
        repeat (2) @(negedge clk);
        start = 1'b1; multiplicand = 8'd5; multiplier = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        repeat (12) @(negedge clk);
        check("ignored_start_done_count", 32'(done_cnt - dc0), 32'd1);

        // asynchronous reset mid-calculation
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd11; multiplier = 8'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        check("no_done_after_reset", 32'(done_cnt - dc0), 32'd0);
        run_one(8'd11, 8'd13, 16'd143);

        // back-to-back with start held high
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; multiplicand = 8'd2; multiplier = 8'd3;
        exp_q.push_back(16'd6);
        wait_done(cyc);
        multiplicand = 8'd4; multiplier = 8'hFC;
        exp_q.push_back(16'hFFF0);
        wait_done(cyc);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("back_to_back_done_count", 32'(done_cnt - dc0), 32'd2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
